ins_writeback_commit: RTL and testbench

Writeback/commit stage placed directly downstream of the instruction-execute units (JALR, JAL, branch, ALU). It accepts one execute result per cycle over a valid/ready handshake and holds it in a single-entry stage register. From that entry it drives the register-file write port and the PC write port, or raises an instruction-address-misaligned trap instead. It also maintains the retired-instruction counter and exposes a forwarding path from the held entry.

---
 rtl/rv_pkg.sv | 35 +++
 rtl/ins_wb_instret.sv | 26 ++
 rtl/ins_writeback_commit.sv | 144 ++++++++++++++
 tb/tb_ins_writeback_commit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: opcodes, trap causes, writeback entry layout
// and the writeback-stage state encoding.
package rv_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;

   localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_FULL      = 2'd1,
      ST_TRAP_HOLD = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [RV_XLEN-1:0] pc;
      logic               pc_w_op;
      logic [RV_XLEN-1:0] tgt;
      logic               reg_w_op;
      logic [4:0]         idx;
      logic [RV_XLEN-1:0] val;
   } wb_entry_t;

   // JALR semantics: the LSB of the computed target is always discarded.
   function automatic logic [RV_XLEN-1:0] align_tgt(input logic [RV_XLEN-1:0] raw);
      return {raw[RV_XLEN-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/ins_wb_instret.sv
// Retired-instruction counter; wraps from all-ones back to zero.
module ins_wb_instret #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_d = cnt_q + CNT_W'(inc_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ins_writeback_commit.sv
// Single-entry writeback/commit stage: commits rd/PC from the held execute
// result or converts a misaligned redirect into a trap. XLEN must match RV_XLEN.
module ins_writeback_commit
   import rv_pkg::*;
#(
   parameter int XLEN  = RV_XLEN,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   // Handshake: a transfer happens on any cycle where ex_valid && ex_ready;
   // the producer keeps ex_* stable while ex_valid is high and ex_ready is low.
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [XLEN-1:0]  ex_pc_val,
   input  logic             ex_pc_w_op,
   input  logic [XLEN-1:0]  ex_pc_w_val,
   input  logic             ex_reg_w_op,
   input  logic [4:0]       ex_reg_w_idx,
   input  logic [XLEN-1:0]  ex_reg_w_val,
   input  logic             wb_stall,
   output logic             rf_w_en,
   output logic [4:0]       rf_w_idx,
   output logic [XLEN-1:0]  rf_w_val,
   output logic             pc_w_en,
   output logic [XLEN-1:0]  pc_w_val,
   output logic             fwd_valid,
   output logic [4:0]       fwd_idx,
   output logic [XLEN-1:0]  fwd_val,
   output logic             trap_valid,
   output logic [3:0]       trap_cause,
   output logic [XLEN-1:0]  trap_epc,
   output logic [XLEN-1:0]  trap_tval,
   input  logic             trap_ack,
   output logic [CNT_W-1:0] instret,
   output logic [1:0]       dbg_state
);

   wb_state_e       state_q, state_d;
   wb_entry_t       entry_q, entry_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic            ready;
   logic            commit;
   logic            mis;
   logic            accept;
   logic            writes_rd;

   assign mis       = entry_q.pc_w_op && entry_q.tgt[1];
   assign writes_rd = entry_q.reg_w_op && (entry_q.idx != 5'd0);

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      epc_d   = epc_q;
      tval_d  = tval_q;
      ready   = 1'b0;
      commit  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            ready = 1'b1;
         end
         ST_FULL: begin
            // A misaligned redirect traps even under stall; the entry never commits.
            if (mis) begin
               state_d = ST_TRAP_HOLD;
               epc_d   = entry_q.pc;
               tval_d  = entry_q.tgt;
            end else if (!wb_stall) begin
               commit  = 1'b1;
               ready   = 1'b1;
               state_d = ST_EMPTY;
            end
         end
         ST_TRAP_HOLD: begin
            if (trap_ack) begin
               state_d = ST_EMPTY;
               entry_d = '0;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      accept = ex_valid && ready;
      if (accept) begin
         state_d          = ST_FULL;
         entry_d.pc       = ex_pc_val;
         entry_d.pc_w_op  = ex_pc_w_op;
         entry_d.tgt      = align_tgt(ex_pc_w_val);
         entry_d.reg_w_op = ex_reg_w_op;
         entry_d.idx      = ex_reg_w_idx;
         entry_d.val      = ex_reg_w_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         entry_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         epc_q   <= epc_d;
         tval_q  <= tval_d;
      end
   end

   ins_wb_instret #(
      .CNT_W (CNT_W)
   ) u_instret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (commit),
      .cnt_o (instret)
   );

   assign ex_ready   = ready;

   assign rf_w_en    = commit && writes_rd;
   assign rf_w_idx   = rf_w_en ? entry_q.idx : 5'd0;
   assign rf_w_val   = rf_w_en ? entry_q.val : '0;

   assign pc_w_en    = commit;
   assign pc_w_val   = !commit         ? '0 :
                       entry_q.pc_w_op ? entry_q.tgt :
                                         entry_q.pc + XLEN'(4);

   // Bypass is visible for the whole time the entry is held, stalled or not.
   assign fwd_valid  = (state_q == ST_FULL) && writes_rd && !mis;
   assign fwd_idx    = fwd_valid ? entry_q.idx : 5'd0;
   assign fwd_val    = fwd_valid ? entry_q.val : '0;

   assign trap_valid = (state_q == ST_TRAP_HOLD);
   assign trap_cause = CAUSE_INSN_MISALIGNED;
   assign trap_epc   = trap_valid ? epc_q  : '0;
   assign trap_tval  = trap_valid ? tval_q : '0;

   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ins_writeback_commit.sv
// Directed and randomized checks of ins_writeback_commit against a queue-based
// model of accepted-but-not-yet-retired instructions.
module tb_ins_writeback_commit;

   localparam int W = 135;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc_val;
   logic        ex_pc_w_op;
   logic [31:0] ex_pc_w_val;
   logic        ex_reg_w_op;
   logic [4:0]  ex_reg_w_idx;
   logic [31:0] ex_reg_w_val;
   logic        wb_stall;
   logic        rf_w_en;
   logic [4:0]  rf_w_idx;
   logic [31:0] rf_w_val;
   logic        pc_w_en;
   logic [31:0] pc_w_val;
   logic        fwd_valid;
   logic [4:0]  fwd_idx;
   logic [31:0] fwd_val;
   logic        trap_valid;
   logic [3:0]  trap_cause;
   logic [31:0] trap_epc;
   logic [31:0] trap_tval;
   logic        trap_ack;
   logic [63:0] instret;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   // Queue entry: {rd_write, idx, val, next_pc, misaligned, pc, target}
   logic [W-1:0] exp_q[$];
   bit           m_trap;
   logic [31:0]  m_epc;
   logic [31:0]  m_tval;
   logic [63:0]  m_cnt;
   bit           m_ready;

   ins_writeback_commit #(.XLEN(32), .CNT_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc_val    (ex_pc_val),
      .ex_pc_w_op   (ex_pc_w_op),
      .ex_pc_w_val  (ex_pc_w_val),
      .ex_reg_w_op  (ex_reg_w_op),
      .ex_reg_w_idx (ex_reg_w_idx),
      .ex_reg_w_val (ex_reg_w_val),
      .wb_stall     (wb_stall),
      .rf_w_en      (rf_w_en),
      .rf_w_idx     (rf_w_idx),
      .rf_w_val     (rf_w_val),
      .pc_w_en      (pc_w_en),
      .pc_w_val     (pc_w_val),
      .fwd_valid    (fwd_valid),
      .fwd_idx      (fwd_idx),
      .fwd_val      (fwd_val),
      .trap_valid   (trap_valid),
      .trap_cause   (trap_cause),
      .trap_epc     (trap_epc),
      .trap_tval    (trap_tval),
      .trap_ack     (trap_ack),
      .instret      (instret),
      .dbg_state    (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input bit pcop,
                        input logic [31:0] tgt, input bit rop, input logic [4:0] idx,
                        input logic [31:0] val, input bit stall, input bit ack);
      ex_valid     = v;
      ex_pc_val    = pc;
      ex_pc_w_op   = pcop;
      ex_pc_w_val  = tgt;
      ex_reg_w_op  = rop;
      ex_reg_w_idx = idx;
      ex_reg_w_val = val;
      wb_stall     = stall;
      trap_ack     = ack;
   endtask

   task automatic idle();
      drive(0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
   endtask

   // Compare every output against what the model says for the current inputs.
   task automatic check_all();
      logic [W-1:0] h;
      bit has, mis, commit;
      #2;
      has    = exp_q.size() != 0;
      h      = has ? exp_q[0] : '0;
      mis    = has && h[64];
      commit = has && !wb_stall && !mis;
      m_ready = !m_trap && (!has || commit);
      chk("ex_ready", ex_ready, m_ready);
      chk("rf_w_en", rf_w_en, commit && h[134]);
      if (commit && h[134]) begin
         chk("rf_w_idx", rf_w_idx, h[133:129]);
         chk("rf_w_val", rf_w_val, h[128:97]);
      end
      chk("pc_w_en", pc_w_en, commit);
      if (commit) chk("pc_w_val", pc_w_val, h[96:65]);
      chk("fwd_valid", fwd_valid, has && h[134] && !mis);
      if (has && h[134] && !mis) begin
         chk("fwd_idx", fwd_idx, h[133:129]);
         chk("fwd_val", fwd_val, h[128:97]);
      end
      chk("trap_valid", trap_valid, m_trap);
      chk("trap_cause", trap_cause, 4'd0);
      if (m_trap) begin
         chk("trap_epc", trap_epc, m_epc);
         chk("trap_tval", trap_tval, m_tval);
      end
      chk("instret", instret, m_cnt);
   endtask

   // Advance one clock and apply the retire/trap/accept rules to the model.
   task automatic tick();
      logic [W-1:0] h;
      logic [31:0]  tgt, npc;
      bit has, mis, commit, ready, acc, ack, rwen;
      has    = exp_q.size() != 0;
      h      = has ? exp_q[0] : '0;
      mis    = has && h[64];
      commit = has && !wb_stall && !mis;
      ready  = !m_trap && (!has || commit);
      acc    = ex_valid && ready;
      ack    = trap_ack;
      tgt    = ex_pc_w_val & ~32'h1;
      npc    = ex_pc_w_op ? tgt : ex_pc_val + 32'd4;
      rwen   = ex_reg_w_op && (ex_reg_w_idx != 5'd0);
      @(posedge clk);
      #1;
      if (m_trap) begin
         if (ack) m_trap = 0;
      end else if (has) begin
         if (mis) begin
            m_trap = 1;
            m_epc  = h[63:32];
            m_tval = h[31:0];
            void'(exp_q.pop_front());
         end else if (commit) begin
            m_cnt = m_cnt + 64'd1;
            void'(exp_q.pop_front());
         end
      end
      if (acc) exp_q.push_back({rwen, ex_reg_w_idx, ex_reg_w_val, npc,
                                ex_pc_w_op && tgt[1], ex_pc_val, tgt});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rf_en"},   rf_w_en, 0);
      chk({tag, "_rf_idx"},  rf_w_idx, 0);
      chk({tag, "_rf_val"},  rf_w_val, 0);
      chk({tag, "_pc_en"},   pc_w_en, 0);
      chk({tag, "_pc_val"},  pc_w_val, 0);
      chk({tag, "_fwd_v"},   fwd_valid, 0);
      chk({tag, "_fwd_idx"}, fwd_idx, 0);
      chk({tag, "_fwd_val"}, fwd_val, 0);
      chk({tag, "_trap_v"},  trap_valid, 0);
      chk({tag, "_cause"},   trap_cause, 0);
      chk({tag, "_epc"},     trap_epc, 0);
      chk({tag, "_tval"},    trap_tval, 0);
      chk({tag, "_instret"}, instret, 0);
      chk({tag, "_state"},   dbg_state, 0);
   endtask

   task automatic mid_reset(input string tag);
      idle();
      rst_n = 1'b0;
      #1;
      chk_zero(tag);
      exp_q.delete();
      m_trap = 0;
      m_cnt  = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [63:0] base;
   logic [31:0] r_pc, r_tgt, r_val;
   logic [4:0]  r_idx;
   bit          r_v, r_pcop, r_rop;

   initial begin
      rst_n  = 1'b0;
      idle();
      m_trap = 0;
      m_cnt  = '0;
      m_epc  = '0;
      m_tval = '0;
      #3;
      chk_zero("rst0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      idle(); check_all(); chk("idle_ready", ex_ready, 1); tick();

      // JALR to 0x205 from 0x100, rd x5 <= 0x104
      drive(1, 32'h100, 1, 32'h205, 1, 5'd5, 32'h104, 0, 0); check_all(); tick();
      idle(); check_all();
      chk("jalr_rf_en", rf_w_en, 1);
      chk("jalr_rf_idx", rf_w_idx, 5);
      chk("jalr_rf_val", rf_w_val, 32'h104);
      chk("jalr_pc", pc_w_val, 32'h204);
      tick();
      chk("jalr_instret", instret, 1);

      // Non-branch writing x0
      drive(1, 32'h40, 0, 32'h0, 1, 5'd0, 32'h55, 0, 0); check_all(); tick();
      idle(); check_all();
      chk("x0_rf_en", rf_w_en, 0);
      chk("x0_fwd", fwd_valid, 0);
      chk("x0_pc", pc_w_val, 32'h44);
      tick();
      chk("x0_instret", instret, 2);

      // Misaligned redirect 0x302 from 0x80
      drive(1, 32'h80, 1, 32'h302, 1, 5'd7, 32'h84, 0, 0); check_all(); tick();
      drive(1, 32'h200, 0, 32'h0, 1, 5'd3, 32'h33, 0, 0); check_all();
      chk("mis_pc_en", pc_w_en, 0);
      chk("mis_rf_en", rf_w_en, 0);
      chk("mis_ready", ex_ready, 0);
      tick();
      check_all();
      chk("trap_valid", trap_valid, 1);
      chk("trap_epc", trap_epc, 32'h80);
      chk("trap_tval", trap_tval, 32'h302);
      chk("trap_ready", ex_ready, 0);
      tick();
      check_all(); tick();
      drive(1, 32'h200, 0, 32'h0, 1, 5'd3, 32'h33, 0, 1); check_all();
      chk("ack_cycle_trap", trap_valid, 1);
      tick();
      drive(1, 32'h200, 0, 32'h0, 1, 5'd3, 32'h33, 0, 0); check_all();
      chk("post_ack_trap", trap_valid, 0);
      chk("post_ack_ready", ex_ready, 1);
      tick();
      idle(); check_all(); chk("post_trap_pc", pc_w_val, 32'h204); tick();
      chk("post_trap_instret", instret, 3);

      // Back-to-back with a two-cycle stall on the second entry
      base = m_cnt;
      drive(1, 32'h300, 0, 32'h0, 1, 5'd1, 32'ha1, 0, 0); check_all(); tick();
      drive(1, 32'h304, 0, 32'h0, 1, 5'd2, 32'hb2, 0, 0); check_all(); tick();
      drive(1, 32'h308, 1, 32'h400, 1, 5'd3, 32'hc3, 1, 0); check_all();
      chk("stall0_ready", ex_ready, 0);
      chk("stall0_pc_en", pc_w_en, 0);
      chk("stall0_fwd", fwd_val, 32'hb2);
      tick();
      check_all(); chk("stall1_ready", ex_ready, 0); tick();
      drive(1, 32'h308, 1, 32'h400, 1, 5'd3, 32'hc3, 0, 0); check_all();
      chk("unstall_val", rf_w_val, 32'hb2);
      tick();
      drive(1, 32'h400, 0, 32'h0, 1, 5'd4, 32'hd4, 0, 0); check_all();
      chk("c_pc", pc_w_val, 32'h400);
      tick();
      idle(); check_all(); tick();
      chk("b2b_count", instret, base + 64'd4);

      // Counter wrap and PC wrap
      idle();
      force dut.u_instret.cnt_d = '1;
      @(posedge clk);
      #1;
      release dut.u_instret.cnt_d;
      m_cnt = '1;
      check_all(); tick();
      drive(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 5'd9, 32'h99, 0, 0); check_all(); tick();
      idle(); check_all(); chk("wrap_pc", pc_w_val, 32'h0); tick();
      chk("wrap_instret", instret, 0);

      // Reset while FULL
      drive(1, 32'h500, 0, 32'h0, 1, 5'd6, 32'h66, 0, 0); check_all(); tick();
      check_all();
      mid_reset("rst_full");
      drive(1, 32'h600, 1, 32'h701, 1, 5'd8, 32'h88, 0, 0); check_all(); tick();
      idle(); check_all(); chk("after_rst_pc", pc_w_val, 32'h700); tick();

      // Reset while TRAP_HOLD
      drive(1, 32'h800, 1, 32'h90A, 0, 5'd0, 32'h0, 0, 0); check_all(); tick();
      idle(); check_all(); tick();
      check_all(); chk("pre_rst_trap", trap_valid, 1);
      mid_reset("rst_trap");
      drive(1, 32'hA00, 0, 32'h0, 1, 5'd10, 32'haa, 0, 0); check_all(); tick();
      idle(); check_all(); chk("after_rst2_val", rf_w_val, 32'haa); tick();

      // Randomized traffic; producer holds data while not accepted
      r_v = 0; r_pc = '0; r_tgt = '0; r_val = '0; r_idx = '0; r_pcop = 0; r_rop = 0;
      for (int i = 0; i < 400; i++) begin
         if (!(r_v && !m_ready)) begin
            r_v    = $urandom_range(0, 3) != 0;
            r_pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_tgt  = $urandom;
            r_pcop = $urandom_range(0, 1) == 1;
            r_rop  = $urandom_range(0, 3) != 0;
            r_idx  = 5'($urandom_range(0, 31));
            r_val  = $urandom;
         end
         drive(r_v, r_pc, r_pcop, r_tgt, r_rop, r_idx, r_val,
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
         check_all();
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
         check_all();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
